dds_sweep_ctrl: RTL and testbench
=================================

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter PERIOD_W, default 12, which sets the width of the DDS period word.
REQ-002 SHALL have parameter DWELL_W, default 16, which sets the width of the dwell counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_start, input, 1 bit: sweep start request, sampled only in IDLE.
REQ-006 SHALL have port i_abort, input, 1 bit: terminates any sweep.
REQ-007 SHALL have port i12_period_start, input, PERIOD_W: first period of the sweep.
REQ-008 SHALL have port i12_period_target, input, PERIOD_W: final period of the sweep.
REQ-009 SHALL have port i12_step, input, PERIOD_W: period delta per step.
REQ-010 SHALL have port i16_dwell, input, DWELL_W: clocks spent at each period.
REQ-011 SHALL have port or12_period, output, PERIOD_W: period word driven to the DDS.
REQ-012 SHALL have port or_busy, output, 1 bit: sweep in progress.
REQ-013 SHALL have port or_done, output, 1 bit: one-cycle pulse on sweep completion.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, DWELL, STEP, DONE.
REQ-015 SHALL, in IDLE with i_start=1 and i_abort=0, capture all i12_*/i16_* inputs and go to LOAD; inputs are ignored at all other times.
REQ-016 SHALL, in LOAD, drive or12_period=start and or_busy=1 on the next cycle, and load the dwell counter, then enter DWELL.
REQ-017 SHALL stay in DWELL for exactly max(dwell,1) cycles, including the first cycle of the period.
REQ-018 SHALL fix the sweep direction at capture: up if target>start, down if target<start.
REQ-019 SHALL, in STEP, go to DONE if or12_period==target; otherwise move or12_period one step toward target, saturating at target with no overshoot, and return to DWELL.
REQ-020 SHALL treat a captured step of 0 as 1 and map any captured period of 0 to 1; or12_period SHALL never be 0.
REQ-021 SHALL, when start==target, hold that period for one dwell and then go to DONE.
REQ-022 SHALL, in DONE, pulse or_done for 1 cycle, clear or_busy, return to IDLE, and hold or12_period at target.
REQ-023 SHALL, on i_abort=1 in any non-IDLE state, enter IDLE next cycle with or_busy=0 and or_done=0, holding the current or12_period.
REQ-024 SHALL, with i_start and i_abort both high in IDLE, let abort win and not start a sweep.
REQ-025 SHALL compute arithmetic at PERIOD_W+1 bits so an up-step at max period cannot wrap.

Reset
REQ-026 SHALL, while rst=0, force state=IDLE, or12_period=1, or_busy=0, or_done=0, dwell counter=0, asynchronously.
REQ-027 SHALL, on reset mid-sweep, discard the sweep; the first start after release behaves as REQ-015.

Configuration
REQ-028 SHALL compile a continuous triangle sweep when DDS_SWEEP_CONT_EN is defined: on reaching target, swap start and target, reverse direction, continue until i_abort, and never pulse or_done.
REQ-029 SHALL, when DDS_SWEEP_CONT_EN is undefined, perform a single sweep per REQ-019 and REQ-022.

Structure
REQ-030 SHALL take the state enum typedef, PERIOD_W default and PERIOD_MIN=1 from shared package dds_pkg.
REQ-031 SHALL place the dwell countdown (load, enable, expire flag) in sub-module dds_dwell_timer.

Verification
REQ-032 SHALL cover up-sweep: start=10, target=14, step=2, dwell=3 -> period 10,12,14 for 3 cycles each; or_done pulses once after the 14 dwell.
REQ-033 SHALL cover saturating down-sweep: start=20, target=15, step=4 -> periods 20,16,15 with no 12.
REQ-034 SHALL cover degenerate inputs: step=0, dwell=0, start=0, target=2 -> periods 1,2 for 1 cycle each, then done.
REQ-035 SHALL cover abort at period 12 of REQ-032 -> busy low next cycle, period stays 12, no done; a later start works normally.
REQ-036 SHALL cover async reset asserted mid-DWELL -> immediate period=1, busy=0, with no clock edge needed.
REQ-037 SHALL cover, with DDS_SWEEP_CONT_EN defined, start=5, target=7, step=1, dwell=1 -> period sequence 5,6,7,6,5,6 with or_done never asserted.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS period sweep controller.
// The state enum is also exported on the debug port so checkers can see the FSM.
package dds_pkg;

  localparam int PERIOD_W_DEF = 12;
  localparam int DWELL_W_DEF  = 16;
  // Smallest legal period word; a zero period would stall the DDS.
  localparam int PERIOD_MIN   = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DWELL = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Bundle of the sweep controller's request/config/status signals.
// master = the agent that requests sweeps; slave = the controller side.
interface dds_sweep_ctrl_if #(
  parameter int PERIOD_W = dds_pkg::PERIOD_W_DEF,
  parameter int DWELL_W  = dds_pkg::DWELL_W_DEF
);
  import dds_pkg::*;

  logic                start;
  logic                abort;
  logic [PERIOD_W-1:0] period_start;
  logic [PERIOD_W-1:0] period_target;
  logic [PERIOD_W-1:0] step;
  logic [DWELL_W-1:0]  dwell;
  logic [PERIOD_W-1:0] period;
  logic                busy;
  logic                done;
  state_e              dbg_state;

  modport master (
    output start, abort, period_start, period_target, step, dwell,
    input  period, busy, done, dbg_state
  );

  modport slave (
    input  start, abort, period_start, period_target, step, dwell,
    output period, busy, done, dbg_state
  );

endinterface

// File: rtl/dds_dwell_timer.sv
// Dwell countdown: load a cycle count, decrement while enabled, flag the last cycle.
// o_expire is high while the count is 1, i.e. on the final cycle of a dwell.
module dds_dwell_timer #(
  parameter int DWELL_W = dds_pkg::DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_load,
  input  logic [DWELL_W-1:0] i_load_val,
  input  logic               i_en,
  output logic               o_expire
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;

  // Next count: clear beats load beats decrement; never decrement below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  // Count register, asynchronously cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expire = (cnt_q == DWELL_W'(1));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS period sweep controller: steps the DDS period word from a start value
// toward a target, dwelling a programmable number of clocks at each period.
// Build option: define DDS_SWEEP_CONT_EN for a continuous triangle sweep
// (bounces between start and target until aborted, never pulses or_done).
//
// Request semantics: i_start is a level sampled only in IDLE; when it is high
// and i_abort is low the configuration inputs are captured and a sweep begins.
// i_abort terminates any sweep on the next clock and wins over i_start.
// There is no ready/back-pressure: or_busy high means requests are ignored.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int DWELL_W  = DWELL_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [PERIOD_W-1:0] i12_period_start,
  input  logic [PERIOD_W-1:0] i12_period_target,
  input  logic [PERIOD_W-1:0] i12_step,
  input  logic [DWELL_W-1:0]  i16_dwell,
  output logic [PERIOD_W-1:0] or12_period,
  output logic                or_busy,
  output logic                or_done,
  output state_e              o_dbg_state
);

  localparam logic [PERIOD_W-1:0] P_MIN = PERIOD_W'(PERIOD_MIN);

  // Zero is not a legal period or step; promote it to the minimum.
  function automatic logic [PERIOD_W-1:0] fix_zero(input logic [PERIOD_W-1:0] v);
    return (v == '0) ? P_MIN : v;
  endfunction

  // One step from cur toward tgt, clamped at tgt. Compared one bit wider so
  // an up-step near the top of the range cannot wrap around.
  function automatic logic [PERIOD_W-1:0] step_toward(
    input logic [PERIOD_W-1:0] cur,
    input logic [PERIOD_W-1:0] tgt,
    input logic [PERIOD_W-1:0] stp,
    input logic                up
  );
    logic [PERIOD_W:0] c;
    logic [PERIOD_W:0] t;
    logic [PERIOD_W:0] s;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    s = {1'b0, stp};
    if (up) begin
      return ((c + s) >= t) ? tgt : (cur + stp);
    end else begin
      return (c <= (t + s)) ? tgt : (cur - stp);
    end
  endfunction

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [PERIOD_W-1:0] start_q, start_d;
  logic [PERIOD_W-1:0] target_q, target_d;
  logic [PERIOD_W-1:0] step_q, step_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic                up_q, up_d;

  logic                tmr_clr;
  logic                tmr_load;
  logic                tmr_en;
  logic                tmr_expire;

  logic [PERIOD_W-1:0] in_start_fix;
  logic [PERIOD_W-1:0] in_target_fix;

  assign in_start_fix  = fix_zero(i12_period_start);
  assign in_target_fix = fix_zero(i12_period_target);

  dds_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (tmr_clr),
    .i_load     (tmr_load),
    .i_load_val (dwell_q),
    .i_en       (tmr_en),
    .o_expire   (tmr_expire)
  );

  // Next-state, output and capture logic; abort overrides everything outside IDLE.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    start_d  = start_q;
    target_d = target_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    up_d     = up_q;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (i_start && !i_abort) begin
          start_d  = in_start_fix;
          target_d = in_target_fix;
          step_d   = fix_zero(i12_step);
          dwell_d  = (i16_dwell == '0) ? DWELL_W'(1) : i16_dwell;
          up_d     = (in_target_fix > in_start_fix);
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        period_d = start_q;
        busy_d   = 1'b1;
        tmr_load = 1'b1;
        state_d  = ST_DWELL;
      end
      ST_DWELL: begin
        tmr_en = 1'b1;
        if (tmr_expire) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        if (period_q == target_q) begin
`ifdef DDS_SWEEP_CONT_EN
          // Bounce: the old start becomes the new target.
          start_d  = target_q;
          target_d = start_q;
          up_d     = !up_q;
          period_d = step_toward(period_q, start_q, step_q, !up_q);
          tmr_load = 1'b1;
          state_d  = ST_DWELL;
`else
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
`endif
        end else begin
          period_d = step_toward(period_q, target_q, step_q, up_q);
          tmr_load = 1'b1;
          state_d  = ST_DWELL;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    if (i_abort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      period_d = period_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      start_d  = start_q;
      target_d = target_q;
      up_d     = up_q;
      tmr_clr  = 1'b1;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
    end
  end

  // State, output and captured-configuration registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      period_q <= P_MIN;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      start_q  <= P_MIN;
      target_q <= P_MIN;
      step_q   <= P_MIN;
      dwell_q  <= '0;
      up_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      start_q  <= start_d;
      target_q <= target_d;
      step_q   <= step_d;
      dwell_q  <= dwell_d;
      up_q     <= up_d;
    end
  end

  assign or12_period = period_q;
  assign or_busy     = busy_q;
  assign or_done     = done_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl. Each sweep is observed cycle by cycle;
// consecutive DWELL cycles are folded into (period, length) runs and compared
// with hand-computed expected runs.
module tb_dds_sweep_ctrl;
  import dds_pkg::*;

  localparam int PW = 12;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dds_sweep_ctrl_if #(.PERIOD_W(PW), .DWELL_W(DW)) sif ();

  dds_sweep_ctrl #(.PERIOD_W(PW), .DWELL_W(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_start           (sif.start),
    .i_abort           (sif.abort),
    .i12_period_start  (sif.period_start),
    .i12_period_target (sif.period_target),
    .i12_step          (sif.step),
    .i16_dwell         (sif.dwell),
    .or12_period       (sif.period),
    .or_busy           (sif.busy),
    .or_done           (sif.done),
    .o_dbg_state       (sif.dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [PW-1:0] exp_q[$];
  int            exp_len_q[$];
  logic [PW-1:0] run_p[$];
  int            run_len[$];
  int            done_cnt;
  int            done_busy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_run(input logic [PW-1:0] p, input int n);
    exp_q.push_back(p);
    exp_len_q.push_back(n);
  endtask

  task automatic check_runs(input string tag);
    check_eq({tag, "_nruns"}, run_p.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < run_p.size(); i++) begin
      check_eq($sformatf("%s_p%0d", tag, i), run_p[i], exp_q[i]);
      check_eq($sformatf("%s_len%0d", tag, i), run_len[i], exp_len_q[i]);
    end
    exp_q.delete();
    exp_len_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request a sweep, then scramble the config inputs to show they are ignored.
  task automatic launch(input logic [PW-1:0] s, input logic [PW-1:0] t,
                        input logic [PW-1:0] stp, input logic [DW-1:0] dw);
    sif.period_start  = s;
    sif.period_target = t;
    sif.step          = stp;
    sif.dwell         = dw;
    sif.start         = 1'b1;
    tick();
    sif.start         = 1'b0;
    sif.period_start  = PW'($urandom_range(0, 4095));
    sif.period_target = PW'($urandom_range(0, 4095));
    sif.step          = PW'($urandom_range(0, 4095));
    sif.dwell         = DW'($urandom_range(0, 20));
  endtask

  // Fold DWELL cycles into runs; optionally stop once the FSM is back in IDLE.
  task automatic observe(input int max_cyc, input bit stop_on_idle);
    bit prev_dwell;
    bit idle_seen;
    prev_dwell = 1'b0;
    idle_seen  = 1'b0;
    run_p.delete();
    run_len.delete();
    done_cnt  = 0;
    done_busy = 0;
    for (int c = 0; c < max_cyc; c++) begin
      if (sif.dbg_state == ST_DWELL) begin
        if (!prev_dwell) begin
          run_p.push_back(sif.period);
          run_len.push_back(1);
        end else begin
          run_len[run_len.size()-1] = run_len[run_len.size()-1] + 1;
        end
        prev_dwell = 1'b1;
      end else begin
        prev_dwell = 1'b0;
      end
      if (sif.done) begin
        done_cnt++;
        if (sif.busy) done_busy++;
      end
      if (stop_on_idle && (sif.dbg_state == ST_IDLE)) begin
        idle_seen = 1'b1;
        break;
      end
      tick();
    end
    if (stop_on_idle) check_eq("reached_idle", idle_seen, 1);
  endtask

  // Wait (bounded) until the DUT dwells at a given period.
  task automatic wait_dwell_at(input logic [PW-1:0] p, input int max_cyc);
    bit found;
    found = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      if ((sif.dbg_state == ST_DWELL) && (sif.period == p)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_eq("wait_dwell_found", found, 1);
  endtask

  // Single up-sweep 10 -> 14, step 2, dwell 3.
  task automatic sweep_up_basic(input string tag);
    launch(12'd10, 12'd14, 12'd2, 16'd3);
    observe(60, 1'b1);
    push_run(12'd10, 3);
    push_run(12'd12, 3);
    push_run(12'd14, 3);
    check_runs(tag);
    check_eq({tag, "_done_cnt"}, done_cnt, 1);
    check_eq({tag, "_done_busy"}, done_busy, 0);
    check_eq({tag, "_end_period"}, sif.period, 14);
    check_eq({tag, "_end_busy"}, sif.busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    sif.start         = 1'b0;
    sif.abort         = 1'b0;
    sif.period_start  = '0;
    sif.period_target = '0;
    sif.step          = '0;
    sif.dwell         = '0;
    rst = 1'b0;
    repeat (3) tick();

    check_eq("rst_period", sif.period, 1);
    check_eq("rst_busy", sif.busy, 0);
    check_eq("rst_done", sif.done, 0);
    check_eq("rst_state", 32'(sif.dbg_state), 32'(ST_IDLE));

    @(negedge clk);
    rst = 1'b1;
    tick();

    // start and abort together in IDLE: abort wins
    sif.start = 1'b1;
    sif.abort = 1'b1;
    tick();
    tick();
    sif.start = 1'b0;
    sif.abort = 1'b0;
    check_eq("both_state", 32'(sif.dbg_state), 32'(ST_IDLE));
    check_eq("both_busy", sif.busy, 0);

`ifdef DDS_SWEEP_CONT_EN
    // triangle sweep 5 <-> 7
    launch(12'd5, 12'd7, 12'd1, 16'd1);
    observe(13, 1'b0);
    push_run(12'd5, 1);
    push_run(12'd6, 1);
    push_run(12'd7, 1);
    push_run(12'd6, 1);
    push_run(12'd5, 1);
    push_run(12'd6, 1);
    check_runs("cont");
    check_eq("cont_done_cnt", done_cnt, 0);
    check_eq("cont_busy", sif.busy, 1);
    sif.abort = 1'b1;
    tick();
    sif.abort = 1'b0;
    check_eq("cont_abort_state", 32'(sif.dbg_state), 32'(ST_IDLE));
    check_eq("cont_abort_busy", sif.busy, 0);
`else
    sweep_up_basic("up");

    // saturating down-sweep 20 -> 15 step 4: no 12
    launch(12'd20, 12'd15, 12'd4, 16'd2);
    observe(60, 1'b1);
    push_run(12'd20, 2);
    push_run(12'd16, 2);
    push_run(12'd15, 2);
    check_runs("down");
    check_eq("down_done_cnt", done_cnt, 1);

    // degenerate: step 0, dwell 0, start 0 -> periods 1,2
    launch(12'd0, 12'd2, 12'd0, 16'd0);
    observe(40, 1'b1);
    push_run(12'd1, 1);
    push_run(12'd2, 1);
    check_runs("degen");
    check_eq("degen_done_cnt", done_cnt, 1);

    // start == target: one dwell then done
    launch(12'd7, 12'd7, 12'd3, 16'd2);
    observe(40, 1'b1);
    push_run(12'd7, 2);
    check_runs("equal");
    check_eq("equal_done_cnt", done_cnt, 1);

    // top of range: 4090 + 10 must clamp at 4095, not wrap
    launch(12'd4090, 12'd4095, 12'd10, 16'd1);
    observe(40, 1'b1);
    push_run(12'd4090, 1);
    push_run(12'd4095, 1);
    check_runs("max");

    // abort while dwelling at 12
    launch(12'd10, 12'd14, 12'd2, 16'd3);
    wait_dwell_at(12'd12, 40);
    sif.abort = 1'b1;
    tick();
    sif.abort = 1'b0;
    check_eq("abort_busy", sif.busy, 0);
    check_eq("abort_done", sif.done, 0);
    check_eq("abort_period", sif.period, 12);
    check_eq("abort_state", 32'(sif.dbg_state), 32'(ST_IDLE));
    observe(6, 1'b0);
    check_eq("abort_no_done", done_cnt, 0);
    check_eq("abort_hold_period", sif.period, 12);
    sweep_up_basic("after_abort");
`endif

    // async reset mid-DWELL, checked before any clock edge
    launch(12'd10, 12'd14, 12'd2, 16'd3);
    tick();
    tick();
    check_eq("pre_rst_state", 32'(sif.dbg_state), 32'(ST_DWELL));
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_period", sif.period, 1);
    check_eq("arst_busy", sif.busy, 0);
    check_eq("arst_state", 32'(sif.dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b1;
    tick();

`ifdef DDS_SWEEP_CONT_EN
    launch(12'd5, 12'd7, 12'd1, 16'd1);
    observe(7, 1'b0);
    push_run(12'd5, 1);
    push_run(12'd6, 1);
    push_run(12'd7, 1);
    check_runs("post_rst");
    sif.abort = 1'b1;
    tick();
    sif.abort = 1'b0;
`else
    launch(12'd0, 12'd2, 12'd0, 16'd0);
    observe(40, 1'b1);
    push_run(12'd1, 1);
    push_run(12'd2, 1);
    check_runs("post_rst");
    check_eq("post_rst_done_cnt", done_cnt, 1);
`endif

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
